key_word_transform: RTL and testbench
=====================================

// Module: key_word_transform
// PURPOSE
//  Parametrised, multi-cycle key-schedule word transform for the AES key expansion.
//  mode=0 (g): RotWord, SubWord, XOR Rcon. mode=1 (h, AES-256 middle word): SubWord only.
//  Keeps its own Rcon register, advanced in GF(2^8) on every completed g operation.
//  Sits between the key-word register file and the key-expansion XOR chain.
//  S-box lane count trades area against latency.
// PARAMETERS
//  SBOX_LANES  4      S-box instances: 1, 2 or 4. Substitutes SBOX_LANES bytes per cycle.
//  OUT_REG     1      1 = extra output register stage (+1 cycle latency); 0 = none.
//  RCON_INIT   8'h01  Rcon value after reset and after rcon_restart.
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   synchronous, active-high reset
//  enable        in   1   start request; accepted only when ready=1
//  mode          in   1   0 = g, 1 = h; sampled at accept
//  rcon_restart  in   1   synchronous reload of Rcon to RCON_INIT
//  data_in       in   32  input word; byte b0 = [31:24] ... b3 = [7:0]; sampled at accept
//  ready         out  1   idle, can accept enable
//  data_out      out  32  transformed word; held until next completion
//  rcon_out      out  8   Rcon the next g operation will use
//  done          out  1   one-cycle pulse, data_out valid
// BEHAVIOUR
//  Reset values: ready=1, done=0, data_out=0, rcon_out=RCON_INIT, FSM=IDLE.
//  Reset during an operation aborts it. No done pulse follows.
//  FSM states:
//   IDLE: ready=1. On enable, capture the work word and go to SUB.
//     g: work word = {b1,b2,b3,b0}; h: work word = data_in unchanged.
//     Also latch mode and latch rcon_used = rcon_out.
//   SUB: each cycle, replace the next SBOX_LANES bytes (most significant first) with S(x).
//     This takes N = 4/SBOX_LANES cycles.
//     On the last SUB edge, go to OUT if OUT_REG=1, else complete.
//   OUT: one register stage, then complete.
//  Completion edge: data_out <= g ? word ^ {rcon_used,24'h0} : word. Set done=1 for one cycle.
//   Return to IDLE on the same edge, so ready=1 while done=1.
//   enable in that cycle is accepted (back-to-back).
//  Latency: done is high in the cycle after edge k+N+OUT_REG, where k is the accept edge.
//   Throughput is one word per N+OUT_REG cycles.
//  enable while ready=0 is ignored; there is no queuing.
//  Rcon update: on a g completion, rcon <= {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
//   It is free-running past 0x36 (0x6c, 0xd8, ...). h completions leave Rcon unchanged.
//  rcon_restart takes priority over a simultaneous g-completion update.
//   An op already accepted still uses its latched rcon_used.
//  S-box: combinational FIPS-197 table per lane. No X propagation from unused lanes.
// TESTING
//  T1 g, data_in=32'h09cf4f3c, Rcon=01 -> data_out=32'h8b84eb01 (FIPS-197 w4 temp), done 1 cycle.
//  T2 h, data_in=32'h09cf4f3c -> data_out=32'h018a84eb, rcon_out unchanged.
//  T3 10 back-to-back g ops on 0 -> Rcon used 01,02,04,08,10,20,40,80,1b,36; rcon_out=8'h6c.
//     First op result = 32'h62636363.
//  T4 For SBOX_LANES in {1,2,4} x OUT_REG in {0,1}: done exactly N+OUT_REG cycles after accept.
//     Check ready low while busy and enable-while-busy ignored.
//  T5 reset mid-SUB -> no done pulse, data_out=0, rcon_out=01, ready=1 after the reset edge.
//  T6 rcon_restart coincident with g completion -> rcon_out=RCON_INIT next cycle.
//     The in-flight op still XORs its latched Rcon.

Source files
------------

// File: rtl/key_word_transform.sv
// AES key-schedule word transform: g (RotWord/SubWord/Rcon) or h (SubWord only).
// SBOX_LANES S-boxes substitute the word over 4/SBOX_LANES cycles, with an optional output stage.
module key_word_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[x];
endmodule

module key_word_transform #(
  parameter int         SBOX_LANES = 4,
  parameter int         OUT_REG    = 1,
  parameter logic [7:0] RCON_INIT  = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        rcon_restart,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic [31:0] data_out,
  output logic [7:0]  rcon_out,
  output logic        done
);
  localparam int N = 4 / SBOX_LANES;

  typedef enum logic [1:0] {IDLE, SUB, OUT} state_t;

  state_t                        state;
  logic [1:0]                    cnt;
  logic [3:0][7:0]               work, work_sub, fin_word;
  logic                          mode_r, last, complete;
  logic [7:0]                    rcon, rcon_used;
  logic [SBOX_LANES-1:0][7:0]    lane_in, lane_out;

  // Byte position in the packed word (index 3 = b0) handled by a lane at a given step.
  function automatic logic [1:0] byte_pos(logic [1:0] step, int lane);
    return 2'(3 - (int'(step) * SBOX_LANES + lane));
  endfunction

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
    assign lane_in[g] = work[byte_pos(cnt, g)];
    key_word_sbox u_sbox (.x(lane_in[g]), .y(lane_out[g]));
  end

  always_comb begin
    work_sub = work;
    for (int i = 0; i < SBOX_LANES; i++) work_sub[byte_pos(cnt, i)] = lane_out[i];
  end

  assign last     = (cnt == 2'(N - 1));
  assign complete = (state == OUT) || (state == SUB && last && OUT_REG == 0);
  assign fin_word = (state == OUT) ? work : work_sub;
  assign ready    = (state == IDLE);
  assign rcon_out = rcon;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      work      <= '0;
      mode_r    <= 1'b0;
      rcon      <= RCON_INIT;
      rcon_used <= RCON_INIT;
      data_out  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          work      <= mode ? data_in : {data_in[23:0], data_in[31:24]};
          mode_r    <= mode;
          rcon_used <= rcon;
          cnt       <= 2'd0;
          state     <= SUB;
        end
        SUB: begin
          work <= work_sub;
          if (last) begin
            cnt <= 2'd0;
            if (OUT_REG != 0) state <= OUT;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: ;
      endcase
      if (complete) begin
        state    <= IDLE;
        done     <= 1'b1;
        data_out <= mode_r ? fin_word : fin_word ^ {rcon_used, 24'h0};
        if (!mode_r) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      // A restart wins over the g-completion advance; the in-flight op keeps rcon_used.
      if (rcon_restart) rcon <= RCON_INIT;
    end
  end
endmodule

// File: tb/tb_key_word_transform.sv
// Runs six DUT configurations (lanes 1/2/4 x OUT_REG 0/1) from shared stimulus against a
// transaction-level model, plus literal FIPS-197 vectors on selected instances.
module tb_key_word_transform;
  localparam int NI = 6;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, mode = 1'b0, rcon_restart = 1'b0;
  logic [31:0] data_in = '0;
  logic [NI-1:0]        ready_v, done_v;
  logic [NI-1:0][31:0]  dout_v;
  logic [NI-1:0][7:0]   rcon_v;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    key_word_transform #(
      .SBOX_LANES(g < 2 ? 1 : (g < 4 ? 2 : 4)),
      .OUT_REG   (g % 2),
      .RCON_INIT (8'h01)
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .rcon_restart(rcon_restart), .data_in(data_in),
      .ready(ready_v[g]), .data_out(dout_v[g]), .rcon_out(rcon_v[g]), .done(done_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: GF(2^8) arithmetic, S-box from inverse + affine map ----
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] xform(logic m, logic [31:0] d, logic [7:0] rc);
    logic [31:0] w = m ? d : {d[23:0], d[31:24]};
    logic [31:0] s;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = sbox(w[8*b +: 8]);
    return m ? s : s ^ {rc, 24'h0};
  endfunction

  function automatic int lat_of(int i);
    return 4 / (i < 2 ? 1 : (i < 4 ? 2 : 4)) + i % 2;
  endfunction

  bit          m_busy [NI];
  bit          m_done [NI];
  bit          m_mode [NI];
  int          m_rem  [NI];
  logic [31:0] m_dout [NI];
  logic [31:0] m_res  [NI];
  logic [7:0]  m_rcon [NI];

  // Outputs are compared mid-cycle; then the model advances using the inputs the next edge samples.
  always @(negedge clk) begin
    if (chk_en)
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("ready[%0d]", i), ready_v[i], m_busy[i] ? 1'b0 : 1'b1);
        chk($sformatf("done[%0d]", i), done_v[i], m_done[i]);
        chk($sformatf("data_out[%0d]", i), dout_v[i], m_dout[i]);
        chk($sformatf("rcon_out[%0d]", i), rcon_v[i], m_rcon[i]);
      end
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_busy[i] = 0; m_done[i] = 0; m_rem[i] = 0; m_dout[i] = '0; m_rcon[i] = 8'h01;
      end else begin
        automatic bit was_idle = !m_busy[i];
        automatic logic [7:0] rc_old = m_rcon[i];
        m_done[i] = 0;
        if (m_busy[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_busy[i] = 0;
            m_done[i] = 1;
            m_dout[i] = m_res[i];
            if (!m_mode[i]) m_rcon[i] = gmul(m_rcon[i], 8'h02);
          end
        end
        if (rcon_restart) m_rcon[i] = 8'h01;
        if (was_idle && enable) begin
          m_busy[i] = 1;
          m_rem[i]  = lat_of(i);
          m_mode[i] = mode;
          m_res[i]  = xform(mode, data_in, rc_old);
        end
      end
    end
  end

  task automatic run_op(input logic m, input logic [31:0] d);
    @(posedge clk); #1 enable = 1'b1; mode = m; data_in = d;
    @(posedge clk); #1 enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; chk_en = 1'b1;

    // FIPS-197 w4 temp (g) and the same word through h
    run_op(1'b0, 32'h09cf4f3c);
    @(negedge clk);
    chk("t1_g_word", dout_v[0], 32'h8b84eb01);
    chk("t1_g_word_l4", dout_v[5], 32'h8b84eb01);
    chk("t1_rcon_next", rcon_v[0], 32'h02);
    run_op(1'b1, 32'h09cf4f3c);
    @(negedge clk);
    chk("t2_h_word", dout_v[2], 32'h018a84eb);
    chk("t2_rcon_kept", rcon_v[2], 32'h02);

    // Rcon walk through ten g ops on zero
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    run_op(1'b0, 32'h0);
    @(negedge clk);
    chk("t3_first_result", dout_v[1], 32'h62636363);
    for (int n = 1; n < 10; n++) run_op(1'b0, 32'h0);
    @(negedge clk);
    chk("t3_rcon_after10", rcon_v[0], 32'h6c);
    chk("t3_rcon_after10_l4", rcon_v[4], 32'h6c);
    chk("t3_last_result", dout_v[3], 32'h63636363 ^ 32'h36000000);

    // Restart on the completion edge of instance 5 (latency 2)
    @(posedge clk); #1 enable = 1'b1; mode = 1'b0; data_in = 32'h0;
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 rcon_restart = 1'b1;
    @(posedge clk); #1 rcon_restart = 1'b0;
    @(negedge clk);
    chk("t6_done", done_v[5], 32'h1);
    chk("t6_latched_rcon", dout_v[5], 32'h0f636363);
    chk("t6_rcon_restart", rcon_v[5], 32'h01);
    repeat (6) @(posedge clk);

    // Enable held high: back-to-back accepts and enable-while-busy ignored
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1
      enable = 1'b1;
      mode = (c % 3 == 2);
      data_in = (32'h01020304 * c) ^ 32'hdeadbeef;
      rcon_restart = (c == 17);
    end
    @(posedge clk); #1 enable = 1'b0; rcon_restart = 1'b0;
    repeat (8) @(posedge clk);

    // Reset mid-SUB on instance 0 (latency 4)
    @(posedge clk); #1 enable = 1'b1; mode = 1'b0; data_in = 32'h12345678;
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    chk("t5_busy_ready", ready_v[0], 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_done", done_v[0], 32'h0);
    chk("t5_data_out", dout_v[0], 32'h0);
    chk("t5_rcon", rcon_v[0], 32'h01);
    chk("t5_ready", ready_v[0], 32'h1);
    repeat (8) @(posedge clk);

    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
